// File: rtl/jtag_scan_if.sv
// Host command/response channel of jtag_scan_sequencer.
// A transfer occurs on a clock edge where valid and ready are both high; valid and its payload hold until then.
interface jtag_scan_if #(
    parameter int MAX_LEN = 256
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// JTAG master generating TCK/TMS/TDI for IR/DR scans and Test-Logic-Reset from one system clock.
// Optional feature macro JTAG_SEQ_AUTO_TLR_EN: run the TLR sequence after every reset.
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 256,
    parameter int CLK_DIV = 2
) (
    input  logic       wb_clk_i,
    input  logic       reset,
    jtag_scan_if.slave bus,
    output logic       busy,
    output logic       TCK,
    output logic       TMS,
    output logic       TDI,
    input  logic       TDO,
    output logic [1:0] fsm_state
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int BIT_W = $clog2(MAX_LEN + 7);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {TLR_SEQ, IDLE, RUN, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_no;
    logic               is_ir;
    logic               is_tlr;
    logic               tlr_rsp;
    logic               tlr_start;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic [MAX_LEN-1:0] rsp_data_q;

    logic [LEN_W-1:0]   len_clamp;
    logic [BIT_W-1:0]   pre;
    logic [BIT_W-1:0]   shift_end;
    logic [BIT_W-1:0]   last_bit;
    logic [BIT_W-1:0]   nxt;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic               cur_shift;
    logic               nxt_tms;
    logic               nxt_tdi;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign fsm_state     = state;

    // Bit map of a scan: prefix [0, pre), shift [pre, shift_end), postfix 1,0.
    always_comb begin
        len_clamp = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
        pre       = is_ir ? BIT_W'(4) : BIT_W'(3);
        shift_end = pre + BIT_W'(len_q);
        last_bit  = is_tlr ? BIT_W'(5) : shift_end + BIT_W'(1);
        nxt       = bit_no + BIT_W'(1);
        cur_shift = !is_tlr && (bit_no >= pre) && (bit_no < shift_end);
        cur_idx   = IDX_W'(bit_no - pre);
        nxt_idx   = IDX_W'(nxt - pre);
        nxt_tms   = 1'b0;
        nxt_tdi   = 1'b0;
        if (is_tlr) begin
            nxt_tms = nxt < BIT_W'(5);
        end else if (nxt < pre) begin
            nxt_tms = is_ir && (nxt == BIT_W'(1));
        end else if (nxt < shift_end) begin
            nxt_tms = nxt == shift_end - BIT_W'(1);
            nxt_tdi = data_q[nxt_idx];
        end else begin
            nxt_tms = nxt == shift_end;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
`ifdef JTAG_SEQ_AUTO_TLR_EN
            state <= TLR_SEQ;
`else
            state <= IDLE;
`endif
            tlr_start   <= 1'b1;
            is_tlr      <= 1'b1;
            tlr_rsp     <= 1'b0;
            is_ir       <= 1'b0;
            cnt         <= '0;
            bit_no      <= '0;
            len_q       <= '0;
            data_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy        <= 1'b1;
            TCK         <= 1'b0;
            TMS         <= 1'b1;
            TDI         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    busy        <= 1'b0;
                    TCK         <= 1'b0;
                    TMS         <= 1'b0;
                    TDI         <= 1'b0;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        tlr_start   <= 1'b0;
                        tlr_rsp     <= 1'b1;
                        rsp_data_q  <= '0;
                        data_q      <= bus.cmd_data;
                        len_q       <= len_clamp;
                        is_ir       <= bus.cmd_op == 2'd1;
                        is_tlr      <= bus.cmd_op[1];
                        cnt         <= '0;
                        bit_no      <= '0;
                        TMS         <= 1'b1;
                        if (bus.cmd_op[1]) begin
                            state <= TLR_SEQ;
                        end else if (len_clamp == '0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            TMS         <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                TLR_SEQ, RUN: begin
                    // After reset, hold one cycle so bit 0 starts on the second cycle, like a command.
                    if (tlr_start) begin
                        tlr_start <= 1'b0;
                    end else begin
                        if (TCK && cnt == '0 && cur_shift) begin
                            rsp_data_q[cur_idx] <= TDO;
                        end
                        if (cnt != CNT_LAST) begin
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            cnt <= '0;
                            if (!TCK) begin
                                TCK <= 1'b1;
                            end else begin
                                TCK <= 1'b0;
                                if (bit_no == last_bit) begin
                                    TMS <= 1'b0;
                                    TDI <= 1'b0;
                                    if (state == RUN || tlr_rsp) begin
                                        state       <= RESP;
                                        rsp_valid_q <= 1'b1;
                                    end else begin
                                        state       <= IDLE;
                                        cmd_ready_q <= 1'b1;
                                        busy        <= 1'b0;
                                    end
                                end else begin
                                    bit_no <= nxt;
                                    TMS    <= nxt_tms;
                                    TDI    <= nxt_tdi;
                                end
                            end
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer driving a behavioural TAP with a 3-bit IR and a bypass register.
module tb_jtag_scan_sequencer;
    localparam int MAX_LEN = 256;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef enum int {
        T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
        T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
    } tap_t;

`ifdef JTAG_SEQ_AUTO_TLR_EN
    localparam int   RST_LAT  = 1 + 12 * CLK_DIV;
    localparam int   RST_BITS = 6;
    localparam tap_t TAP_PWR  = T_RTI;
    localparam tap_t TAP_MID  = T_RTI;
`else
    localparam int   RST_LAT  = 1;
    localparam int   RST_BITS = 0;
    localparam tap_t TAP_PWR  = T_TLR;
    localparam tap_t TAP_MID  = T_SH_DR;
`endif

    typedef struct {
        logic [1:0]         op;
        int                 len;
        logic [MAX_LEN-1:0] data;
        logic [MAX_LEN-1:0] exp_rsp;
        int                 bits;
        int                 lat;
    } vec_t;

    logic       wb_clk_i = 1'b0;
    logic       reset    = 1'b1;
    logic       busy;
    logic       TCK;
    logic       TMS;
    logic       TDI;
    logic       TDO      = 1'b0;
    logic [1:0] fsm_state;

    jtag_scan_if #(.MAX_LEN(MAX_LEN)) bus ();

    jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .wb_clk_i  (wb_clk_i),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- TAP model ----------------
    tap_t       tap_state = T_TLR;
    logic [2:0] ir_sr     = 3'b000;
    logic [2:0] ir        = 3'b111;
    logic       byp       = 1'b0;
    int         tck_rises = 0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:    return m ? T_TLR    : T_RTI;
            T_RTI:    return m ? T_SEL_DR : T_RTI;
            T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
            T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
            T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
            T_EX1_DR: return m ? T_UPD_DR : T_PA_DR;
            T_PA_DR:  return m ? T_EX2_DR : T_PA_DR;
            T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
            T_UPD_DR: return m ? T_SEL_DR : T_RTI;
            T_SEL_IR: return m ? T_TLR    : T_CAP_IR;
            T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
            T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
            T_EX1_IR: return m ? T_UPD_IR : T_PA_IR;
            T_PA_IR:  return m ? T_EX2_IR : T_PA_IR;
            T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
            default:  return m ? T_SEL_DR : T_RTI;
        endcase
    endfunction

    // Every instruction routes DR scans through the one-bit bypass path in this model.
    always @(posedge TCK) begin
        tck_rises++;
        case (tap_state)
            T_CAP_IR: ir_sr <= 3'b001;
            T_SH_IR:  ir_sr <= {TDI, ir_sr[2:1]};
            T_UPD_IR: ir    <= ir_sr;
            T_TLR:    ir    <= 3'b111;
            T_CAP_DR: byp   <= 1'b0;
            T_SH_DR:  byp   <= TDI;
            default:  ;
        endcase
        tap_state <= tap_next(tap_state, TMS);
    end

    always @(negedge TCK) begin
        TDO <= (tap_state == T_SH_IR) ? ir_sr[0] : (tap_state == T_SH_DR) ? byp : 1'b0;
    end

    // TMS/TDI must never move while TCK is high or on its rising edge.
    int   edge_viol = 0;
    logic prev_tms  = 1'b1;
    logic prev_tdi  = 1'b0;
    always @(negedge wb_clk_i) begin
        if (!reset && TCK && (TMS != prev_tms || TDI != prev_tdi)) edge_viol++;
        prev_tms = TMS;
        prev_tdi = TDI;
    end

    // ---------------- scoreboard ----------------
    logic [MAX_LEN-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [MAX_LEN-1:0] act, input logic [MAX_LEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 3000) begin
            tick();
            n++;
        end
        check_int("cmd_ready before issue", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 3000) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_cmd(input string name, input vec_t v);
        int b0;
        int lat;
        logic [MAX_LEN-1:0] exp;
        b0 = tck_rises;
        exp_q.push_back(v.exp_rsp);
        issue(v.op, v.len, v.data);
        wait_rsp(lat);
        check_int({name, " latency"}, lat, v.lat);
        check_int({name, " tck bits"}, tck_rises - b0, v.bits);
        exp = exp_q.pop_front();
        check({name, " rsp_data"}, bus.rsp_data, exp);
        check_int({name, " tap in idle"}, int'(tap_state), int'(T_RTI));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic release_reset(input string name, input tap_t exp_tap);
        int n;
        int b0;
        b0    = tck_rises;
        reset = 1'b0;
        n     = 0;
        do begin
            tick();
            n++;
        end while (!bus.cmd_ready && n < 500);
        check_int({name, " cycles to cmd_ready"}, n, RST_LAT);
        check_int({name, " TMS in idle"}, int'(TMS), 0);
        check_int({name, " tck bits"}, tck_rises - b0, RST_BITS);
        check_int({name, " tap state"}, int'(tap_state), int'(exp_tap));
    endtask

    task automatic check_reset_values(input string name);
        check_int({name, " cmd_ready"}, int'(bus.cmd_ready), 0);
        check_int({name, " rsp_valid"}, int'(bus.rsp_valid), 0);
        check({name, " rsp_data"}, bus.rsp_data, '0);
        check_int({name, " outs busy/TCK/TMS/TDI"}, int'({busy, TCK, TMS, TDI}), int'(4'b1010));
    endtask

    // ---------------- test ----------------
    vec_t vecs[10];

    function automatic vec_t mk(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data,
                                input logic [MAX_LEN-1:0] exp_rsp, input int bits, input int lat);
        vec_t v;
        v.op = op; v.len = len; v.data = data; v.exp_rsp = exp_rsp; v.bits = bits; v.lat = lat;
        return v;
    endfunction

    initial begin
        int lat;
        int b0;
        logic [MAX_LEN-1:0] pat;

        pat = {8{32'hDEADBEEF}};
        vecs[0] = mk(2'd2, 0,   '0,              '0,          6,   25);
        vecs[1] = mk(2'd1, 3,   '0,              256'h1,      9,   37);
        vecs[2] = mk(2'd1, 3,   256'h7,          256'h1,      9,   37);
        vecs[3] = mk(2'd0, 8,   256'hA5,         256'h4A,     13,  53);
        vecs[4] = mk(2'd0, 1,   256'h1,          '0,          6,   25);
        vecs[5] = mk(2'd0, 16,  256'hF00F,       256'hE01E,   21,  85);
        vecs[6] = mk(2'd0, 0,   {MAX_LEN{1'b1}}, '0,          0,   1);
        vecs[7] = mk(2'd0, 4,   {MAX_LEN{1'b1}}, 256'hE,      9,   37);
        vecs[8] = mk(2'd3, 7,   256'h55,         '0,          6,   25);
        vecs[9] = mk(2'd0, MAX_LEN + 5, pat,     pat << 1,    MAX_LEN + 5, 1 + 4 * (MAX_LEN + 5));

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;

        // Power-up reset
        tick();
        tick();
        check_reset_values("por");
        release_reset("por", TAP_PWR);

        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i]);
        end

        // Response stall, then a command offered in the same cycle as the response handshake
        issue(2'd0, 8, 256'hA5);
        wait_rsp(lat);
        check_int("stall latency", lat, 53);
        b0 = tck_rises;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_int($sformatf("stall c%0d valid/ready/tck/data", c),
                      int'({bus.rsp_valid, bus.cmd_ready, TCK, bus.rsp_data[7:0]}),
                      int'({1'b1, 1'b0, 1'b0, 8'h4A}));
        end
        check_int("stall tck bits", tck_rises - b0, 0);
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_len   = LEN_W'(1);
        bus.cmd_data  = '0;
        tick();
        bus.rsp_ready = 1'b0;
        check_int("b2b after handshake valid/ready/busy", int'({bus.rsp_valid, bus.cmd_ready, busy}),
                  int'(3'b010));
        check("b2b rsp_data held", bus.rsp_data, 256'h4A);
        tick();
        bus.cmd_valid = 1'b0;
        check_int("b2b accepted ready/busy", int'({bus.cmd_ready, busy}), int'(2'b01));
        check("b2b rsp_data cleared", bus.rsp_data, '0);
        wait_rsp(lat);
        check_int("b2b latency", lat, 25);
        check("b2b rsp_data", bus.rsp_data, '0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset during shift bit 100 of a 248-bit DR scan
        b0 = tck_rises;
        issue(2'd0, 248, pat);
        for (int c = 1; c < 414; c++) tick();
        check_int("midscan tck bits before reset", tck_rises - b0, 103);
        check_int("midscan busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        check_reset_values("midscan");
        tick();
        release_reset("midscan", TAP_MID);
        run_cmd("recover tlr", vecs[0]);
        run_cmd("recover bypass", vecs[3]);

        check_int("tms/tdi change with TCK high", edge_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
